coloring: RTL and testbench

Pseudo-colour point operator, the inverse direction of the graying block: takes one `color_width`-bit gray sample and produces a packed `{R,G,B}` pixel using a fixed four-segment blue→cyan→green→yellow→red ramp. It sits in the Image/Point pipeline after graying or other single-channel stages. It uses the same `in_enable` / `in_data` / `out_ready` / `out_data` contract as graying, in either pipeline or request/acknowledge mode.

---
 rtl/coloring_pkg.sv | 30 +++
 rtl/coloring_if.sv | 34 +++
 rtl/coloring_map.sv | 37 +++
 rtl/coloring.sv | 156 +++++++++++++++
 tb/tb_coloring.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/coloring_pkg.sv
`default_nettype none
// ============================================================================
// Module  : coloring_pkg
// Purpose : Shared types and constants for the coloring pseudo-colour block.
//           FSM state encoding for the request/acknowledge datapath, ramp
//           segment indices and work-mode selector values.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package coloring_pkg;

    // Request/acknowledge handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } coloring_state_t;

    // Ramp segments: blue->cyan, cyan->green, green->yellow, yellow->red
    localparam logic [1:0] SEG_BC = 2'd0;
    localparam logic [1:0] SEG_CG = 2'd1;
    localparam logic [1:0] SEG_GY = 2'd2;
    localparam logic [1:0] SEG_YR = 2'd3;

    // work_mode selector values
    localparam int MODE_PIPELINE = 0;
    localparam int MODE_REQACK   = 1;

endpackage
`default_nettype wire

// File: rtl/coloring_if.sv
`default_nettype none
// ============================================================================
// Module  : coloring_if
// Purpose : Sample/pixel handshake bundle for the coloring block.
// Ports   : in_enable  - sample valid (pipeline) / request (req/ack)
//           in_data    - gray sample, color_width bits
//           out_ready  - output valid (pipeline) / acknowledge (req/ack)
//           out_data   - {R,G,B}, 3*color_width bits, R in the MSBs
//           master modport drives the sample side, slave is the block.
// Revision: 1.0 - initial release
// ============================================================================
interface coloring_if #(
    parameter int color_width = 8
) ();
    logic                       in_enable;
    logic [color_width-1:0]     in_data;
    logic                       out_ready;
    logic [3*color_width-1:0]   out_data;

    modport master (
        output in_enable,
        output in_data,
        input  out_ready,
        input  out_data
    );

    modport slave (
        input  in_enable,
        input  in_data,
        output out_ready,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/coloring_map.sv
`default_nettype none
// ============================================================================
// Module  : coloring_map
// Purpose : Combinational ramp-segment to RGB selector.
// Ports   : seg  in  2      - ramp segment (gray MSBs)
//           ramp in  W      - ramp value spanning 0..M
//           rgb  out 3*W    - {R,G,B}
// Revision: 1.0 - initial release
// ============================================================================
module coloring_map
    import coloring_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic [1:0]     seg,
    input  wire logic [W-1:0]   ramp,
    output logic      [3*W-1:0] rgb
);
    localparam logic [W-1:0] FULL = {W{1'b1}};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    // FULL - ramp cannot underflow since ramp is W bits wide
    logic [W-1:0] ramp_inv;
    assign ramp_inv = FULL - ramp;

    always_comb begin
        rgb = {ZERO, ZERO, ZERO};
        case (seg)
            SEG_BC:  rgb = {ZERO, ramp,     FULL};
            SEG_CG:  rgb = {ZERO, FULL,     ramp_inv};
            SEG_GY:  rgb = {ramp, FULL,     ZERO};
            SEG_YR:  rgb = {FULL, ramp_inv, ZERO};
            default: rgb = {ZERO, ZERO, ZERO};
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/coloring.sv
`default_nettype none
// ============================================================================
// Module  : coloring
// Purpose : Pseudo-colour point operator: gray sample -> {R,G,B} using a
//           four-segment blue/cyan/green/yellow/red ramp.
//           work_mode 0: 3-stage pipeline, 1 sample/cycle, no back-pressure.
//           work_mode 1: IDLE->CALC->DONE request/acknowledge handshake.
//           Optional macro COLORING_INVERT_EN maps M-g instead of g.
// Ports   : clk    in  1 - clock, rising edge
//           rst_n  in  1 - asynchronous active-low reset
//           bus    slave modport of coloring_if (in_enable, in_data,
//                  out_ready, out_data)
// Revision: 1.0 - initial release
// ============================================================================
module coloring
    import coloring_pkg::*;
#(
    parameter int work_mode   = 0,
    parameter int color_width = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    coloring_if.slave   bus
);
    localparam int           W    = color_width;
    localparam logic [W-1:0] FULL = {W{1'b1}};

    // Gray value feeding the segment/ramp split, chosen by the active mode
    logic [W-1:0]   src_g;
    logic [W-1:0]   eff_g;
    logic [1:0]     split_seg;
    logic [W-1:0]   split_ramp;

    // Shared map inputs/outputs
    logic [1:0]     map_seg;
    logic [W-1:0]   map_ramp;
    logic [3*W-1:0] map_rgb;

`ifdef COLORING_INVERT_EN
    assign eff_g = FULL - src_g;
`else
    assign eff_g = src_g;
`endif

    // Ramp replicates the top fraction bits into the LSBs so it reaches FULL
    assign split_seg  = eff_g[W-1:W-2];
    assign split_ramp = {eff_g[W-3:0], eff_g[W-3:W-4]};

    coloring_map #(
        .W (W)
    ) u_map (
        .seg  (map_seg),
        .ramp (map_ramp),
        .rgb  (map_rgb)
    );

    if (work_mode == MODE_PIPELINE) begin : g_pipeline
        logic           s1_valid;
        logic [W-1:0]   s1_g;
        logic           s2_valid;
        logic [1:0]     s2_seg;
        logic [W-1:0]   s2_ramp;
        logic           s3_valid;
        logic [3*W-1:0] s3_rgb;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_g     <= '0;
                s2_valid <= 1'b0;
                s2_seg   <= '0;
                s2_ramp  <= '0;
                s3_valid <= 1'b0;
                s3_rgb   <= '0;
            end else begin
                s1_valid <= bus.in_enable;
                if (bus.in_enable) begin
                    s1_g <= bus.in_data;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_seg  <= split_seg;
                    s2_ramp <= split_ramp;
                end
                s3_valid <= s2_valid;
                // Output word only moves on valid data; holds through bubbles
                if (s2_valid) begin
                    s3_rgb <= map_rgb;
                end
            end
        end

        assign src_g        = s1_g;
        assign map_seg      = s2_seg;
        assign map_ramp     = s2_ramp;
        assign bus.out_ready = s3_valid;
        assign bus.out_data  = s3_rgb;
    end else begin : g_reqack
        coloring_state_t state, state_nxt;
        logic [W-1:0]    cap_g, cap_g_nxt;
        logic            ready, ready_nxt;
        logic [3*W-1:0]  rgb, rgb_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cap_g <= '0;
                ready <= 1'b0;
                rgb   <= '0;
            end else begin
                state <= state_nxt;
                cap_g <= cap_g_nxt;
                ready <= ready_nxt;
                rgb   <= rgb_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cap_g_nxt = cap_g;
            ready_nxt = ready;
            rgb_nxt   = rgb;
            case (state)
                IDLE: begin
                    // in_data is only looked at here
                    if (bus.in_enable) begin
                        cap_g_nxt = bus.in_data;
                        state_nxt = CALC;
                    end
                end
                CALC: begin
                    rgb_nxt   = map_rgb;
                    ready_nxt = 1'b1;
                    state_nxt = DONE;
                end
                DONE: begin
                    if (!bus.in_enable) begin
                        ready_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    ready_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end

        assign src_g         = cap_g;
        assign map_seg       = split_seg;
        assign map_ramp      = split_ramp;
        assign bus.out_ready = ready;
        assign bus.out_data  = rgb;
    end
endmodule
`default_nettype wire

// File: tb/tb_coloring.sv
`default_nettype none
// ============================================================================
// Module  : tb_coloring
// Purpose : Directed self-checking bench for coloring, W=8. One instance in
//           pipeline mode, one in request/acknowledge mode, sharing clk and
//           rst_n. Honours COLORING_INVERT_EN when defined.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_coloring;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    coloring_if #(.color_width(8)) pif ();
    coloring_if #(.color_width(8)) rif ();

    coloring #(.work_mode(0), .color_width(8)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif.slave)
    );

    coloring #(.work_mode(1), .color_width(8)) u_reqack (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus value for a nominal gray level: under inversion drive the
    // complement so the same hand-computed colour is expected.
    function automatic logic [7:0] tb_in(input logic [7:0] g);
`ifdef COLORING_INVERT_EN
        return 8'hFF - g;
`else
        return g;
`endif
    endfunction

    // Reference colour for a raw sample driven into the DUT
    function automatic logic [23:0] ref_rgb(input logic [7:0] g);
        logic [7:0] gg;
        logic [7:0] r;
        gg = g;
`ifdef COLORING_INVERT_EN
        gg = 8'hFF - g;
`endif
        r = {gg[5:0], gg[5:4]};
        case (gg[7:6])
            2'd0:    return {8'h00, r, 8'hFF};
            2'd1:    return {8'h00, 8'hFF, 8'hFF - r};
            2'd2:    return {r, 8'hFF, 8'h00};
            default: return {8'hFF, 8'hFF - r, 8'h00};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  g_tab [5];
    logic [23:0] e_tab [5];
    logic        pat   [4];
    logic [7:0]  dat   [4];
    logic [23:0] last_p;
    logic [23:0] held;
    logic        exp_rdy;

    initial begin
        checks = 0;
        errors = 0;
        g_tab = '{8'd0, 8'd64, 8'd100, 8'd128, 8'd255};
        e_tab = '{24'h0000FF, 24'h00FFFF, 24'h00FF6D, 24'h00FF00, 24'hFF0000};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        dat   = '{8'd10, 8'd20, 8'd30, 8'd40};

        rst_n         = 1'b0;
        pif.in_enable = 1'b0;
        pif.in_data   = 8'd0;
        rif.in_enable = 1'b0;
        rif.in_data   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_p_ready", {31'd0, pif.out_ready}, 32'd0);
        check("reset_p_data",  {8'd0, pif.out_data},   32'd0);
        check("reset_r_ready", {31'd0, rif.out_ready}, 32'd0);
        check("reset_r_data",  {8'd0, rif.out_data},   32'd0);
        rst_n = 1'b1;

        // ---------------- pipeline single samples ----------------
        for (int i = 0; i < 5; i++) begin
            pif.in_enable = 1'b1;
            pif.in_data   = tb_in(g_tab[i]);
            step();
            pif.in_enable = 1'b0;
            pif.in_data   = 8'h5A;
            step();
            check("single_early_ready", {31'd0, pif.out_ready}, 32'd0);
            step();
            check("single_ready", {31'd0, pif.out_ready}, 32'd1);
            check("single_data",  {8'd0, pif.out_data},   {8'd0, e_tab[i]});
            step();
            check("single_ready_drop", {31'd0, pif.out_ready}, 32'd0);
            check("single_data_hold",  {8'd0, pif.out_data},   {8'd0, e_tab[i]});
        end

        // ---------------- pipeline continuous stream ----------------
        last_p = e_tab[4];
        for (int c = 0; c < 260; c++) begin
            pif.in_enable = (c < 256);
            pif.in_data   = 8'(c);
            step();
            exp_rdy = (c >= 2) && (c - 2 < 256);
            check("stream_ready", {31'd0, pif.out_ready}, {31'd0, exp_rdy});
            if (exp_rdy) begin
                last_p = ref_rgb(8'(c - 2));
                check("stream_data", {8'd0, pif.out_data}, {8'd0, last_p});
            end
        end

        // ---------------- pipeline bubbles 1,0,0,1 ----------------
        for (int c = 0; c < 7; c++) begin
            pif.in_enable = (c < 4) ? pat[c] : 1'b0;
            pif.in_data   = (c < 4) ? dat[c] : 8'hEE;
            step();
            exp_rdy = (c >= 2) && (c - 2 < 4) && pat[(c >= 2 && c < 6) ? c - 2 : 0];
            if (exp_rdy) last_p = ref_rgb(dat[c - 2]);
            check("bubble_ready", {31'd0, pif.out_ready}, {31'd0, exp_rdy});
            check("bubble_data",  {8'd0, pif.out_data},   {8'd0, last_p});
        end

        // ---------------- req/ack handshake ----------------
        rif.in_enable = 1'b1;
        rif.in_data   = tb_in(8'd100);
        step();
        check("ra_ack_early", {31'd0, rif.out_ready}, 32'd0);
        rif.in_data   = 8'h33;  // ignored outside IDLE
        step();
        check("ra_ack",  {31'd0, rif.out_ready}, 32'd1);
        check("ra_data", {8'd0, rif.out_data},   32'h00FF6D);
        for (int k = 0; k < 5; k++) begin
            rif.in_data = 8'(k * 37);
            step();
            check("ra_hold_ready", {31'd0, rif.out_ready}, 32'd1);
            check("ra_hold_data",  {8'd0, rif.out_data},   32'h00FF6D);
        end
        rif.in_enable = 1'b0;
        step();
        check("ra_release",   {31'd0, rif.out_ready}, 32'd0);
        check("ra_data_kept", {8'd0, rif.out_data},   32'h00FF6D);
        // Back-to-back request right after release
        rif.in_enable = 1'b1;
        rif.in_data   = tb_in(8'd0);
        step();
        check("ra2_ack_early", {31'd0, rif.out_ready}, 32'd0);
        step();
        check("ra2_ack",  {31'd0, rif.out_ready}, 32'd1);
        check("ra2_data", {8'd0, rif.out_data},   32'h0000FF);
        rif.in_enable = 1'b0;
        step();
        check("ra2_release", {31'd0, rif.out_ready}, 32'd0);

        // ---------------- reset mid-stream / mid-handshake ----------------
        rif.in_enable = 1'b1;
        rif.in_data   = tb_in(8'd128);
        pif.in_enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            pif.in_data = tb_in(8'd64);
            step();
        end
        held = rif.out_data;
        check("pre_rst_r_ready", {31'd0, rif.out_ready}, 32'd1);
        check("pre_rst_r_data",  {8'd0, held},           32'h00FF00);
        check("pre_rst_p_ready", {31'd0, pif.out_ready}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_p_ready", {31'd0, pif.out_ready}, 32'd0);
        check("async_rst_p_data",  {8'd0, pif.out_data},   32'd0);
        check("async_rst_r_ready", {31'd0, rif.out_ready}, 32'd0);
        check("async_rst_r_data",  {8'd0, rif.out_data},   32'd0);
        pif.in_enable = 1'b1;
        pif.in_data   = tb_in(8'd255);
        rif.in_enable = 1'b1;
        rif.in_data   = tb_in(8'd255);
        step();
        step();
        check("rst_held_p_ready", {31'd0, pif.out_ready}, 32'd0);
        rst_n = 1'b1;

        step();
        pif.in_enable = 1'b0;
        check("post_rst_r_early", {31'd0, rif.out_ready}, 32'd0);
        step();
        check("post_rst_r_ready", {31'd0, rif.out_ready}, 32'd1);
        check("post_rst_r_data",  {8'd0, rif.out_data},   32'hFF0000);
        check("post_rst_p_early", {31'd0, pif.out_ready}, 32'd0);
        step();
        check("post_rst_p_ready", {31'd0, pif.out_ready}, 32'd1);
        check("post_rst_p_data",  {8'd0, pif.out_data},   32'hFF0000);
        rif.in_enable = 1'b0;
        step();
        check("post_rst_p_drop", {31'd0, pif.out_ready}, 32'd0);
        check("post_rst_r_drop", {31'd0, rif.out_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
